// File: rtl/encoder.sv
// Registered 4-to-2 encoder with one-hot checking; 1-cycle latency, async active-low reset.
// Define ENCODER_PRIORITY_EN to resolve multi-hot inputs to the highest set bit instead of flagging them.
module encoder #(
  parameter logic [1:0] DEFAULT_Y = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  output logic [1:0] y,
  output logic       valid,
  output logic       err
);

  logic [1:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  always_comb begin
    y_d     = DEFAULT_Y;
    valid_d = 1'b0;
    err_d   = 1'b1;
`ifdef ENCODER_PRIORITY_EN
    // Ascending scan: the last set bit seen is the highest one, so it wins.
    for (int i = 0; i < 4; i++) begin
      if (data[i]) begin
        y_d     = 2'(i);
        valid_d = 1'b1;
        err_d   = 1'b0;
      end
    end
`else
    unique case (data)
      4'b0001: begin y_d = 2'd0; valid_d = 1'b1; err_d = 1'b0; end
      4'b0010: begin y_d = 2'd1; valid_d = 1'b1; err_d = 1'b0; end
      4'b0100: begin y_d = 2'd2; valid_d = 1'b1; err_d = 1'b0; end
      4'b1000: begin y_d = 2'd3; valid_d = 1'b1; err_d = 1'b0; end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= DEFAULT_Y;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder: stimulus pushes model results, a monitor pops and compares each cycle.
module tb_encoder;

  localparam logic [1:0] DEF_Y = 2'b00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] data = 4'b1000;
  logic [1:0] y;
  logic       valid;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];   // {y, valid, err}

  encoder #(.DEFAULT_Y(DEF_Y)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .y     (y),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Reference: count set bits and locate the highest one.
  function automatic logic [3:0] model(input logic [3:0] d);
    int         ones;
    logic [1:0] hi;
    ones = $countones(d);
    hi   = 2'd0;
    for (int i = 0; i < 4; i++)
      if (d[i]) hi = 2'(i);
`ifdef ENCODER_PRIORITY_EN
    if (ones >= 1) return {hi, 2'b10};
`else
    if (ones == 1) return {hi, 2'b10};
`endif
    return {DEF_Y, 2'b01};
  endfunction

  function automatic void check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got y/valid/err=%b/%b/%b required %b/%b/%b",
                  name, act[3:2], act[1], act[0], req[3:2], req[1], req[0]);
  endfunction

  task automatic send(input logic [3:0] d);
    @(negedge clk);
    data = d;
    exp_q.push_back(model(d));
    $display("send data=%b", d);
  endtask

  // Monitor: outputs reflect the sample taken at the preceding rising edge.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {y, valid, err}, e);
        $display("mon y=%b valid=%b err=%b exp=%b", y, valid, err, e);
      end
    end
  end

  initial begin
    logic [3:0] hold;
    #1 rst_n = 1'b0;
    #1 check("reset_async", {y, valid, err}, {DEF_Y, 2'b00});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2 check("reset_hold", {y, valid, err}, {DEF_Y, 2'b00});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // One-hot sweep, zero, multi-hot
    send(4'b0001); send(4'b0010); send(4'b0100); send(4'b1000);
    send(4'b0000);
    send(4'b1010); send(4'b0111); send(4'b1111); send(4'b0110);

    // Latency: a mid-cycle data change must not reach the outputs before the next edge.
    send(4'b0001);
    @(posedge clk);
    #2 hold = {y, valid, err};
    data = 4'b0100;
    #2 check("no_comb_path", {y, valid, err}, hold);
    send(4'b0100);

    // Async reset mid-run while y=11
    send(4'b1000);
    @(posedge clk);
    #3 exp_q.delete();
    rst_n = 1'b0;
    #1 check("reset_mid_run", {y, valid, err}, {DEF_Y, 2'b00});
    @(posedge clk);
    #2 check("reset_mid_hold", {y, valid, err}, {DEF_Y, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    data = 4'b0010;
    exp_q.push_back(model(4'b0010));

    for (int i = 0; i < 200; i++)
      send(4'($urandom_range(0, 15)));

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
